sm83_irq: RTL and testbench
===========================

SM83_IRQ -- requirements
Module: sm83_irq

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, data word width.
REQ-002 SHALL have parameter NUM_IRQS, default 8, interrupt line count, legal range 1..WORD_SIZE.
REQ-003 SHALL have parameter VEC_BASE, default 16'h0040, address of vector 0.
REQ-004 SHALL have parameter VEC_STRIDE, default 8, address distance between consecutive vectors.
REQ-005 SHALL have parameter ADR_WIDTH, default 2*WORD_SIZE, vector width.
REQ-006 Ports SHALL be as follows (name, direction, width, meaning):
clk  in  1  clock.
reset  in  1  reset, synchronous, active-high.
irq  in  NUM_IRQS  level request lines; rising edge latches the IF bit.
ie_we  in  1  write reg_din into IE.
if_we  in  1  write reg_din into IF.
reg_din  in  WORD_SIZE  register write data.
ie_dout  out  WORD_SIZE  IE contents.
if_dout  out  WORD_SIZE  IF contents; bits >= NUM_IRQS read 1.
ei  in  1  EI executed, one-cycle pulse.
di  in  1  DI executed, one-cycle pulse.
reti  in  1  RETI executed; sets IME immediately.
instr_done  in  1  instruction boundary pulse.
int_req  out  1  dispatch request to the sequencer.
int_ack  in  1  sequencer accepts the dispatch.
vec_sel  in  1  sequencer requests vector resolution.
vector  out  ADR_WIDTH  resolved jump target.
iack  out  NUM_IRQS  one-hot acknowledge, one cycle.
wake  out  1  |(IE & IF) regardless of IME, combinational; HALT exit.

Function
REQ-007 IF[i] SHALL be set on the cycle after irq[i] rises (irq & ~irq_prev).
REQ-008 IF_next SHALL be ((if_we ? reg_din : IF) & ~iack_clear) | edge, so an edge beats both a write and a clear in the same cycle.
REQ-009 IE SHALL store all WORD_SIZE bits; only bits < NUM_IRQS participate in arbitration.
REQ-010 ei SHALL set ei_pend; at the next instr_done with ei_pend set, IME SHALL become 1 and ei_pend 0; the dispatch check on that same cycle SHALL use the old IME, giving a one-instruction delay.
REQ-011 di SHALL clear IME and ei_pend immediately, and SHALL win over ei or reti in the same cycle.
REQ-012 The FSM SHALL have three states: IDLE, REQ and DISPATCH.
REQ-013 IDLE->REQ SHALL occur on instr_done && IME && |(IE & IF); int_req SHALL be 1 only in REQ.
REQ-014 REQ->DISPATCH SHALL occur on int_ack; IME SHALL clear on the same edge; a di in REQ SHALL return the FSM to IDLE without acknowledging.
REQ-015 In DISPATCH, vec_sel SHALL arbitrate the IE & IF value of that cycle, lowest index first (late arbitration).
REQ-016 When an interrupt wins, on the next edge: iack SHALL be one-hot for one cycle, the winning IF bit SHALL clear, vector SHALL equal VEC_BASE + idx*VEC_STRIDE (mod 2^ADR_WIDTH), and the FSM SHALL return to IDLE.
REQ-017 If nothing is pending at vec_sel (cancelled), vector SHALL be 0, iack SHALL be 0, IME SHALL remain 0 and the FSM SHALL return to IDLE.
REQ-018 vector SHALL hold its value until the next resolution.
REQ-019 int_ack outside REQ and vec_sel outside DISPATCH SHALL be ignored.

Reset
REQ-020 On reset: IME=0, ei_pend=0, IE=0, IF=0, irq_prev=0, state=IDLE, int_req=0, iack=0, vector=0.
REQ-021 Reset in any state, including mid-dispatch, SHALL abort the dispatch with no iack and no IF change other than clearing.
REQ-022 Because irq_prev resets to 0, an irq held high through reset SHALL set IF on the first cycle after reset.

Structure
REQ-023 Package sm83_pkg SHALL hold the word_t/adr_t typedefs, the FSM state enum and the default vector constants.
REQ-024 A combinational sub-module sm83_irq_prio (lowest-index-first encoder, index plus valid output) SHALL be used for arbitration.

Verification
REQ-025 IE=0x01, IME=1, pulse irq[0] -> IF=0xE1; at instr_done int_req=1; int_ack, then vec_sel -> vector=0x0040, iack=0x01, IF=0xE0, IME=0.
REQ-026 IE=0x1F, IF written 0x14, dispatch -> vector=0x0050 (idx 2), iack=0x04, IF then reads 0xF0.
REQ-027 ei, instr_done (EI end) with pending IE&IF -> no int_req; next instr_done -> int_req=1.
REQ-028 After int_ack, write IF=0 before vec_sel -> vector=0x0000, iack=0, IME=0.
REQ-029 irq[3] edge in the same cycle as if_we with reg_din=0x00 -> IF bit 3 reads 1; with IME=0 and IE bit 3 set, wake=1 and int_req stays 0.
REQ-030 NUM_IRQS=4, VEC_STRIDE=16: dispatch idx 3 -> vector=0x0070; if_dout upper nibble reads 0xF; reset during DISPATCH -> FSM in IDLE, iack=0.

Source files
------------

// File: rtl/sm83_pkg.sv
// Shared types and default constants for the SM83 interrupt controller.
// Contents: word/address typedefs, dispatch FSM state encoding and the
// default vector placement used by sm83_irq parameters.
package sm83_pkg;

  localparam int unsigned WORD_SIZE_DEF  = 8;
  localparam int unsigned NUM_IRQS_DEF   = 8;
  localparam int unsigned ADR_WIDTH_DEF  = 2 * WORD_SIZE_DEF;
  localparam int unsigned VEC_BASE_DEF   = 16'h0040;
  localparam int unsigned VEC_STRIDE_DEF = 8;

  typedef logic [WORD_SIZE_DEF-1:0] word_t;
  typedef logic [ADR_WIDTH_DEF-1:0] adr_t;

  // Dispatch sequencer handshake states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_DISPATCH = 2'd2
  } state_e;

endpackage

// File: rtl/sm83_irq_prio.sv
// Lowest-index-first priority encoder used for interrupt arbitration.
// Ports:
//   req   - request vector, bit 0 has highest priority
//   idx   - index of the winning request (0 when nothing requested)
//   valid - at least one request bit is set
module sm83_irq_prio #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top so the lowest set bit is the last (winning) assignment
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sm83_irq.sv
// SM83 interrupt controller: IE/IF registers, IME with delayed EI,
// request/acknowledge/vector dispatch handshake with late arbitration.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   irq               - level request lines, rising edge latches IF
//   ie_we/if_we       - register writes from reg_din
//   ie_dout/if_dout   - register readback (unused IF bits read 1)
//   ei/di/reti        - instruction side effects on IME
//   instr_done        - instruction boundary, dispatch check point
//   int_req/int_ack   - dispatch request handshake with the sequencer
//   vec_sel           - sequencer asks for the jump target
//   vector/iack       - resolved target and one-hot acknowledge
//   wake              - pending-and-enabled, ignores IME (HALT exit)
module sm83_irq
  import sm83_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = WORD_SIZE_DEF,
  parameter int unsigned NUM_IRQS   = NUM_IRQS_DEF,
  parameter int unsigned VEC_BASE   = VEC_BASE_DEF,
  parameter int unsigned VEC_STRIDE = VEC_STRIDE_DEF,
  parameter int unsigned ADR_WIDTH  = 2 * WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_IRQS-1:0]  irq,
  input  logic                 ie_we,
  input  logic                 if_we,
  input  logic [WORD_SIZE-1:0] reg_din,
  output logic [WORD_SIZE-1:0] ie_dout,
  output logic [WORD_SIZE-1:0] if_dout,
  input  logic                 ei,
  input  logic                 di,
  input  logic                 reti,
  input  logic                 instr_done,
  output logic                 int_req,
  input  logic                 int_ack,
  input  logic                 vec_sel,
  output logic [ADR_WIDTH-1:0] vector,
  output logic [NUM_IRQS-1:0]  iack,
  output logic                 wake
);

  localparam int unsigned IDX_W = (NUM_IRQS > 1) ? $clog2(NUM_IRQS) : 1;
  // Bits of IF that correspond to real interrupt lines
  localparam logic [WORD_SIZE-1:0] IRQ_MASK = {WORD_SIZE{1'b1}} >> (WORD_SIZE - NUM_IRQS);

  state_e               state_q, state_d;
  logic                 ime_q, ime_d;
  logic                 ei_pend_q, ei_pend_d;
  logic [WORD_SIZE-1:0] ie_q;
  logic [WORD_SIZE-1:0] if_q, if_d;
  logic [NUM_IRQS-1:0]  irq_prev;
  logic [ADR_WIDTH-1:0] vector_q, vector_d;
  logic [NUM_IRQS-1:0]  iack_q, iack_d;
  logic                 int_req_q;

  logic [WORD_SIZE-1:0] pending;
  logic [WORD_SIZE-1:0] edge_w;
  logic [WORD_SIZE-1:0] clr;
  logic [NUM_IRQS-1:0]  win_hot;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_valid;
  logic                 resolve;

  // IF only ever holds real line bits, so the AND needs no extra mask
  assign pending = ie_q & if_q;
  assign edge_w  = WORD_SIZE'(irq & ~irq_prev);
  assign resolve = (state_q == ST_DISPATCH) && vec_sel;

  sm83_irq_prio #(
    .N     (NUM_IRQS),
    .IDX_W (IDX_W)
  ) u_prio (
    .req   (pending[NUM_IRQS-1:0]),
    .idx   (win_idx),
    .valid (win_valid)
  );

  assign win_hot = (resolve && win_valid) ? (NUM_IRQS'(1) << win_idx) : '0;
  assign clr     = WORD_SIZE'(win_hot);

  // Next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    ime_d     = ime_q;
    ei_pend_d = ei_pend_q;
    vector_d  = vector_q;
    iack_d    = '0;

    // New edges win over both a register write and the acknowledge clear
    if_d = (((if_we ? reg_din : if_q) & ~clr) | edge_w) & IRQ_MASK;

    case (state_q)
      ST_IDLE: begin
        // ime_q is the pre-update value, which yields the EI delay slot
        if (instr_done && ime_q && (|pending)) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (di)           state_d = ST_IDLE;
        else if (int_ack) state_d = ST_DISPATCH;
      end
      ST_DISPATCH: begin
        if (vec_sel) begin
          state_d = ST_IDLE;
          iack_d  = win_hot;
          vector_d = win_valid
                   ? ADR_WIDTH'(VEC_BASE) + ADR_WIDTH'(win_idx) * ADR_WIDTH'(VEC_STRIDE)
                   : '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (instr_done && ei_pend_q) begin
      ime_d     = 1'b1;
      ei_pend_d = 1'b0;
    end
    if (ei)   ei_pend_d = 1'b1;
    if (reti) ime_d     = 1'b1;
    if ((state_q == ST_REQ) && int_ack && !di) ime_d = 1'b0;
    if (di) begin
      ime_d     = 1'b0;
      ei_pend_d = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ime_q     <= 1'b0;
      ei_pend_q <= 1'b0;
      ie_q      <= '0;
      if_q      <= '0;
      irq_prev  <= '0;
      vector_q  <= '0;
      iack_q    <= '0;
      int_req_q <= 1'b0;
    end else begin
      ime_q     <= ime_d;
      ei_pend_q <= ei_pend_d;
      if (ie_we) ie_q <= reg_din;
      if_q      <= if_d;
      irq_prev  <= irq;
      vector_q  <= vector_d;
      iack_q    <= iack_d;
      int_req_q <= (state_d == ST_REQ);
    end
  end

  assign ie_dout = ie_q;
  assign if_dout = if_q | ~IRQ_MASK;
  assign int_req = int_req_q;
  assign vector  = vector_q;
  assign iack    = iack_q;
  assign wake    = |pending;

endmodule

// File: tb/tb_sm83_irq.sv
// Directed bench for sm83_irq: instance a (5 lines, default vectors) and
// instance b (4 lines, stride 16) with hand-computed expectations.
module tb_sm83_irq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Instance a: NUM_IRQS=5
  logic        a_reset, a_ie_we, a_if_we, a_ei, a_di, a_reti, a_instr_done;
  logic        a_int_ack, a_vec_sel, a_int_req, a_wake;
  logic [4:0]  a_irq, a_iack;
  logic [7:0]  a_reg_din, a_ie_dout, a_if_dout;
  logic [15:0] a_vector;

  // Instance b: NUM_IRQS=4, VEC_STRIDE=16
  logic        b_reset, b_ie_we, b_if_we, b_ei, b_di, b_reti, b_instr_done;
  logic        b_int_ack, b_vec_sel, b_int_req, b_wake;
  logic [3:0]  b_irq, b_iack;
  logic [7:0]  b_reg_din, b_ie_dout, b_if_dout;
  logic [15:0] b_vector;

  sm83_irq #(.NUM_IRQS(5)) u_a (
    .clk(clk), .reset(a_reset), .irq(a_irq), .ie_we(a_ie_we), .if_we(a_if_we),
    .reg_din(a_reg_din), .ie_dout(a_ie_dout), .if_dout(a_if_dout),
    .ei(a_ei), .di(a_di), .reti(a_reti), .instr_done(a_instr_done),
    .int_req(a_int_req), .int_ack(a_int_ack), .vec_sel(a_vec_sel),
    .vector(a_vector), .iack(a_iack), .wake(a_wake)
  );

  sm83_irq #(.NUM_IRQS(4), .VEC_STRIDE(16)) u_b (
    .clk(clk), .reset(b_reset), .irq(b_irq), .ie_we(b_ie_we), .if_we(b_if_we),
    .reg_din(b_reg_din), .ie_dout(b_ie_dout), .if_dout(b_if_dout),
    .ei(b_ei), .di(b_di), .reti(b_reti), .instr_done(b_instr_done),
    .int_req(b_int_req), .int_ack(b_int_ack), .vec_sel(b_vec_sel),
    .vector(b_vector), .iack(b_iack), .wake(b_wake)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    a_reset = 1'b1; a_irq = '0; a_ie_we = 1'b0; a_if_we = 1'b0; a_reg_din = '0;
    a_ei = 1'b0; a_di = 1'b0; a_reti = 1'b0; a_instr_done = 1'b0;
    a_int_ack = 1'b0; a_vec_sel = 1'b0;
    b_reset = 1'b1; b_irq = '0; b_ie_we = 1'b0; b_if_we = 1'b0; b_reg_din = '0;
    b_ei = 1'b0; b_di = 1'b0; b_reti = 1'b0; b_instr_done = 1'b0;
    b_int_ack = 1'b0; b_vec_sel = 1'b0;
    tick(); tick();
    a_reset = 1'b0; b_reset = 1'b0;
    tick();

    // Reset state
    check("rst_if_a", 32'(a_if_dout), 32'hE0);
    check("rst_ie_a", 32'(a_ie_dout), 32'h00);
    check("rst_req_a", 32'(a_int_req), 32'h0);
    check("rst_vec_a", 32'(a_vector), 32'h0);
    check("rst_iack_a", 32'(a_iack), 32'h0);
    check("rst_wake_a", 32'(a_wake), 32'h0);
    check("rst_if_b", 32'(b_if_dout), 32'hF0);

    // Single line dispatch, vector 0
    a_ie_we = 1'b1; a_reg_din = 8'h01; tick(); a_ie_we = 1'b0;
    check("ie_wr", 32'(a_ie_dout), 32'h01);
    a_reti = 1'b1; tick(); a_reti = 1'b0;
    a_irq = 5'b00001; tick(); a_irq = '0;
    check("if_edge0", 32'(a_if_dout), 32'hE1);
    check("wake0", 32'(a_wake), 32'h1);
    check("no_req_early", 32'(a_int_req), 32'h0);
    a_instr_done = 1'b1; tick(); a_instr_done = 1'b0;
    check("req0", 32'(a_int_req), 32'h1);
    a_int_ack = 1'b1; tick(); a_int_ack = 1'b0;
    check("req0_drop", 32'(a_int_req), 32'h0);
    a_vec_sel = 1'b1; tick(); a_vec_sel = 1'b0;
    check("vec0", 32'(a_vector), 32'h0040);
    check("iack0", 32'(a_iack), 32'h01);
    check("if_clr0", 32'(a_if_dout), 32'hE0);
    tick();
    check("iack0_pulse", 32'(a_iack), 32'h00);
    // IME cleared by the acknowledge: a new pending request is not taken
    a_irq = 5'b00001; tick(); a_irq = '0;
    a_instr_done = 1'b1; tick(); a_instr_done = 1'b0;
    check("ime_off_req", 32'(a_int_req), 32'h0);
    a_if_we = 1'b1; a_reg_din = 8'h00; tick(); a_if_we = 1'b0;

    // Lowest index wins among several pending
    a_ie_we = 1'b1; a_reg_din = 8'h1F; tick(); a_ie_we = 1'b0;
    a_if_we = 1'b1; a_reg_din = 8'h14; tick(); a_if_we = 1'b0;
    check("if_wr14", 32'(a_if_dout), 32'hF4);
    a_reti = 1'b1; tick(); a_reti = 1'b0;
    a_instr_done = 1'b1; tick(); a_instr_done = 1'b0;
    check("req2", 32'(a_int_req), 32'h1);
    a_int_ack = 1'b1; tick(); a_int_ack = 1'b0;
    a_vec_sel = 1'b1; tick(); a_vec_sel = 1'b0;
    check("vec2", 32'(a_vector), 32'h0050);
    check("iack2", 32'(a_iack), 32'h04);
    check("if_clr2", 32'(a_if_dout), 32'hF0);
    tick();
    check("vec_hold", 32'(a_vector), 32'h0050);

    // EI delay slot: bit 4 pending, IME=0
    a_ei = 1'b1; tick(); a_ei = 1'b0;
    a_instr_done = 1'b1; tick(); a_instr_done = 1'b0;
    check("ei_delay", 32'(a_int_req), 32'h0);
    a_instr_done = 1'b1; tick(); a_instr_done = 1'b0;
    check("ei_req", 32'(a_int_req), 32'h1);

    // Cancelled dispatch: IF cleared between int_ack and vec_sel
    a_int_ack = 1'b1; tick(); a_int_ack = 1'b0;
    a_if_we = 1'b1; a_reg_din = 8'h00; tick(); a_if_we = 1'b0;
    check("if_cancel", 32'(a_if_dout), 32'hE0);
    a_vec_sel = 1'b1; tick(); a_vec_sel = 1'b0;
    check("vec_cancel", 32'(a_vector), 32'h0000);
    check("iack_cancel", 32'(a_iack), 32'h00);
    a_if_we = 1'b1; a_reg_din = 8'h01; tick(); a_if_we = 1'b0;
    a_instr_done = 1'b1; tick(); a_instr_done = 1'b0;
    check("ime_cancel", 32'(a_int_req), 32'h0);
    a_if_we = 1'b1; a_reg_din = 8'h00; tick(); a_if_we = 1'b0;

    // Edge beats a same-cycle IF write of zero; wake ignores IME
    a_irq = 5'b01000; a_if_we = 1'b1; a_reg_din = 8'h00; tick();
    a_irq = '0; a_if_we = 1'b0;
    check("edge_vs_wr", 32'(a_if_dout), 32'hE8);
    check("wake3", 32'(a_wake), 32'h1);
    a_instr_done = 1'b1; tick(); a_instr_done = 1'b0;
    check("noime_req3", 32'(a_int_req), 32'h0);

    // DI in REQ returns to IDLE; later int_ack/vec_sel ignored
    a_reti = 1'b1; tick(); a_reti = 1'b0;
    a_instr_done = 1'b1; tick(); a_instr_done = 1'b0;
    check("req3", 32'(a_int_req), 32'h1);
    a_di = 1'b1; tick(); a_di = 1'b0;
    check("di_abort", 32'(a_int_req), 32'h0);
    a_int_ack = 1'b1; tick(); a_int_ack = 1'b0;
    a_vec_sel = 1'b1; tick(); a_vec_sel = 1'b0;
    check("stray_iack", 32'(a_iack), 32'h00);
    check("stray_vec", 32'(a_vector), 32'h0000);
    check("if_kept3", 32'(a_if_dout), 32'hE8);

    // Instance b: idx 3 with stride 16
    b_ie_we = 1'b1; b_reg_din = 8'h08; tick(); b_ie_we = 1'b0;
    b_if_we = 1'b1; b_reg_din = 8'h08; tick(); b_if_we = 1'b0;
    check("b_if_wr", 32'(b_if_dout), 32'hF8);
    b_reti = 1'b1; tick(); b_reti = 1'b0;
    b_instr_done = 1'b1; tick(); b_instr_done = 1'b0;
    check("b_req", 32'(b_int_req), 32'h1);
    b_int_ack = 1'b1; tick(); b_int_ack = 1'b0;
    b_vec_sel = 1'b1; tick(); b_vec_sel = 1'b0;
    check("b_vec3", 32'(b_vector), 32'h0070);
    check("b_iack3", 32'(b_iack), 32'h8);
    check("b_if_clr", 32'(b_if_dout), 32'hF0);

    // Reset in DISPATCH aborts; irq held through reset latches afterwards
    b_if_we = 1'b1; b_reg_din = 8'h08; tick(); b_if_we = 1'b0;
    b_reti = 1'b1; tick(); b_reti = 1'b0;
    b_instr_done = 1'b1; tick(); b_instr_done = 1'b0;
    b_int_ack = 1'b1; tick(); b_int_ack = 1'b0;
    b_reset = 1'b1; b_vec_sel = 1'b1; b_irq = 4'b0010; tick();
    check("b_rst_iack", 32'(b_iack), 32'h0);
    check("b_rst_vec", 32'(b_vector), 32'h0);
    check("b_rst_if", 32'(b_if_dout), 32'hF0);
    check("b_rst_req", 32'(b_int_req), 32'h0);
    b_reset = 1'b0; b_vec_sel = 1'b0; tick();
    check("b_held_irq", 32'(b_if_dout), 32'hF2);
    b_vec_sel = 1'b1; tick(); b_vec_sel = 1'b0;
    check("b_idle_iack", 32'(b_iack), 32'h0);
    check("b_idle_vec", 32'(b_vector), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
